// File: rtl/frame_rx_if.sv
// PHY-side receive stream, external CRC hookup and MAC-side payload/status
// signals of the frame receiver, bundled for the frame_rx port list.
interface frame_rx_if #(
   parameter int LEN_W = 11
);
   logic             rxdv;
   logic [7:0]       rxd;
   logic             crc_clr;
   logic             crc_en;
   logic [31:0]      crc;
   logic [7:0]       mac_rxd;
   logic             mac_rxdv;
   logic             fs_mac;
   logic             fd;
   logic             frame_ok;
   logic             frame_err;
   logic [LEN_W-1:0] len;

   modport slave (
      input  rxdv, rxd, crc,
      output crc_clr, crc_en, mac_rxd, mac_rxdv, fs_mac, fd, frame_ok, frame_err, len
   );

   modport master (
      output rxdv, rxd, crc,
      input  crc_clr, crc_en, mac_rxd, mac_rxdv, fs_mac, fd, frame_ok, frame_err, len
   );
endinterface

// File: rtl/frame_rx.sv
// GMII receive framer: strips preamble/SFD, forwards payload through a 4-byte
// FCS holdback while driving an external CRC-32, then reports frame status.
module frame_rx #(
   parameter int MIN_PRE = 2,
   parameter int MAX_LEN = 1514,
   parameter int LEN_W   = 11
) (
   input logic       clk,
   input logic       rst,
   frame_rx_if.slave bus
);
   localparam int               BW      = LEN_W + 1;
   localparam logic [2:0]       PRE_MIN = 3'(MIN_PRE);
   localparam logic [BW-1:0]    OVF_AT  = BW'(MAX_LEN + 4);
   localparam logic [BW-1:0]    BC_SAT  = {BW{1'b1}};
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, WAIT, HUNT, WORK, CHK, DONE} state_t;

   state_t           state_r;
   logic             rxdv_r;
   logic [7:0]       rxd_r;
   logic [2:0]       pcnt_r;
   logic [BW-1:0]    bcnt_r;
   logic [7:0]       h3_r, h2_r, h1_r, h0_r;
   logic             ovf_r;
   logic             crc_clr_r, crc_en_r, mac_rxdv_r, fs_mac_r, fd_r, ok_r, err_r;
   logic [7:0]       mac_rxd_r;
   logic [LEN_W-1:0] len_r;
   logic             good_s;
   logic [BW-1:0]    pay_s;
   logic [LEN_W-1:0] len_s;

   // Input capture of the PHY receive stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxdv_r <= 1'b0;
         rxd_r  <= 8'h00;
      end else begin
         rxdv_r <= bus.rxdv;
         rxd_r  <= bus.rxd;
      end
   end

   // Frame verdict and reported length, consumed in CHK once crc has settled.
   always_comb begin
      pay_s  = bcnt_r - BW'(4);
      good_s = ({h3_r, h2_r, h1_r, h0_r} == bus.crc) && (bcnt_r >= BW'(5)) && !ovf_r;
      if (ovf_r) begin
         len_s = LEN_MAX;
      end else if (bcnt_r >= BW'(4)) begin
         len_s = pay_s[LEN_W-1:0];
      end else begin
         len_s = {LEN_W{1'b0}};
      end
   end

   // Receive state machine with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         pcnt_r     <= 3'd0;
         bcnt_r     <= {BW{1'b0}};
         {h3_r, h2_r, h1_r, h0_r} <= 32'h0000_0000;
         ovf_r      <= 1'b0;
         crc_clr_r  <= 1'b0;
         crc_en_r   <= 1'b0;
         mac_rxdv_r <= 1'b0;
         mac_rxd_r  <= 8'h00;
         fs_mac_r   <= 1'b0;
         fd_r       <= 1'b0;
         ok_r       <= 1'b0;
         err_r      <= 1'b0;
         len_r      <= {LEN_W{1'b0}};
      end else begin
         crc_clr_r  <= 1'b0;
         crc_en_r   <= 1'b0;
         mac_rxdv_r <= 1'b0;
         fd_r       <= 1'b0;
         ok_r       <= 1'b0;
         err_r      <= 1'b0;
         case (state_r)
            IDLE: begin
               crc_clr_r <= 1'b1;
               state_r   <= WAIT;
            end
            WAIT: begin
               if (!rxdv_r) begin
                  pcnt_r  <= 3'd0;
                  state_r <= HUNT;
               end
            end
            HUNT: begin
               if (!rxdv_r) begin
                  pcnt_r <= 3'd0;
               end else if (rxd_r == 8'h55) begin
                  if (pcnt_r != 3'd7) pcnt_r <= pcnt_r + 3'd1;
               end else if (rxd_r == 8'hD5 && pcnt_r >= PRE_MIN) begin
                  state_r   <= WORK;
                  fs_mac_r  <= 1'b1;
                  crc_clr_r <= 1'b1;
                  bcnt_r    <= {BW{1'b0}};
                  ovf_r     <= 1'b0;
                  {h3_r, h2_r, h1_r, h0_r} <= 32'h0000_0000;
               end else begin
                  state_r <= WAIT;
               end
            end
            WORK: begin
               if (rxdv_r) begin
                  {h3_r, h2_r, h1_r, h0_r} <= {h2_r, h1_r, h0_r, rxd_r};
                  if (bcnt_r != BC_SAT) bcnt_r <= bcnt_r + BW'(1);
                  // h3 is known to be payload only once four newer bytes exist.
                  if (bcnt_r >= BW'(4)) begin
                     if (bcnt_r >= OVF_AT) begin
                        ovf_r <= 1'b1;
                     end else begin
                        mac_rxd_r  <= h3_r;
                        mac_rxdv_r <= 1'b1;
                        crc_en_r   <= 1'b1;
                     end
                  end
               end else begin
                  state_r <= CHK;
               end
            end
            CHK: begin
               fd_r     <= 1'b1;
               ok_r     <= good_s;
               err_r    <= !good_s;
               len_r    <= len_s;
               fs_mac_r <= 1'b0;
               state_r  <= DONE;
            end
            DONE: begin
               pcnt_r  <= 3'd0;
               state_r <= HUNT;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.crc_clr   = crc_clr_r;
   assign bus.crc_en    = crc_en_r;
   assign bus.mac_rxd   = mac_rxd_r;
   assign bus.mac_rxdv  = mac_rxdv_r;
   assign bus.fs_mac    = fs_mac_r;
   assign bus.fd        = fd_r;
   assign bus.frame_ok  = ok_r;
   assign bus.frame_err = err_r;
   assign bus.len       = len_r;
endmodule

// File: tb/tb_frame_rx.sv
// Randomized scoreboard bench for frame_rx with an external CRC-32 unit model
// and a frame-level reference model of preamble hunting, holdback and status.
module tb_frame_rx;
   localparam int MIN_PRE = 2;
   localparam int MAX_LEN = 1514;
   localparam int LEN_W   = 11;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   frame_rx_if #(.LEN_W(LEN_W)) bus();
   frame_rx #(.MIN_PRE(MIN_PRE), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int phase = 0;           // 0 scoreboard, 1 unchecked, 2 outputs must stay quiet
   bit prev_acc = 1'b0;
   int last_gap = 0;

   logic [7:0] exp_b[$];
   int         exp_t[$];
   bit         exp_ok[$];
   int         exp_len[$];

   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      logic        b;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         b = c[31] ^ d[i];
         c = {c[30:0], 1'b0};
         if (b) c = c ^ 32'h04C1_1DB7;
      end
      return c;
   endfunction

   // External CRC unit: registered, seeded by crc_clr, absorbs mac_rxd on crc_en.
   logic [31:0] crc_q = 32'h0;
   always @(posedge clk) begin
      if (bus.crc_clr) crc_q <= 32'hFFFF_FFFF;
      else if (bus.crc_en) crc_q <= crc_upd(crc_q, bus.mac_rxd);
   end
   assign bus.crc = crc_q;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic miss(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: DUT output with no expected entry at cycle %0d", nm, cyc);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a byte or a status.
   always @(negedge clk) begin
      if (phase == 0 && !rst) begin
         if (bus.mac_rxdv) begin
            if (exp_b.size() == 0) begin
               miss("mac_extra");
            end else begin
               chk("mac_rxd", 32'(bus.mac_rxd), 32'(exp_b.pop_front()));
               chk("mac_latency", 32'(cyc), 32'(exp_t.pop_front()));
               chk("crc_en", 32'(bus.crc_en), 32'd1);
               chk("fs_mac_data", 32'(bus.fs_mac), 32'd1);
            end
         end else if (bus.crc_en) begin
            miss("crc_en_stray");
         end
         if (bus.fd) begin
            if (exp_ok.size() == 0) begin
               miss("fd_extra");
            end else begin
               chk("frame_ok", 32'(bus.frame_ok), 32'(exp_ok[0]));
               chk("frame_err", 32'(bus.frame_err), 32'(!exp_ok[0]));
               chk("len", 32'(bus.len), 32'(exp_len[0]));
               chk("fs_mac_done", 32'(bus.fs_mac), 32'd0);
               void'(exp_ok.pop_front());
               void'(exp_len.pop_front());
            end
         end else begin
            chk("status_idle", 32'({bus.frame_ok, bus.frame_err}), 32'd0);
         end
      end else if (phase == 2) begin
         chk("quiet", 32'({bus.mac_rxdv, bus.crc_en, bus.fd, bus.fs_mac}), 32'd0);
      end
   end

   task automatic put(input logic v, input logic [7:0] d, output int c);
      @(posedge clk);
      #1;
      bus.rxdv = v;
      bus.rxd  = d;
      c = cyc;
   endtask

   task automatic idle(input int n);
      int c;
      for (int i = 0; i < n; i++) put(1'b0, 8'($urandom), c);
      last_gap += n;
   endtask

   function automatic bq_t pre_ok(input int p);
      bq_t q;
      for (int i = 0; i < p; i++) q.push_back(8'h55);
      q.push_back(8'hD5);
      return q;
   endfunction

   function automatic bq_t rnd_bytes(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   function automatic bq_t with_fcs(input bq_t pay, input bit corrupt);
      bq_t q;
      logic [31:0] c;
      q = pay;
      c = 32'hFFFF_FFFF;
      foreach (pay[i]) c = crc_upd(c, pay[i]);
      q.push_back(c[31:24]);
      q.push_back(c[23:16]);
      q.push_back(c[15:8]);
      q.push_back(corrupt ? (c[7:0] ^ 8'h01) : c[7:0]);
      return q;
   endfunction

   function automatic bit fcs_good(input bq_t body);
      int n;
      logic [31:0] c;
      n = body.size();
      if (n < 4) return 1'b0;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) c = crc_upd(c, body[i]);
      return {body[n-4], body[n-3], body[n-2], body[n-1]} == c;
   endfunction

   // Preamble acceptance seen from the first byte the hunter actually observes.
   function automatic bit accepts(input bq_t pre, input int lost);
      int cnt;
      cnt = 0;
      for (int i = lost; i < pre.size(); i++) begin
         if (pre[i] == 8'h55) cnt++;
         else return (pre[i] == 8'hD5) && (cnt >= MIN_PRE) && (i == pre.size() - 1);
      end
      return 1'b0;
   endfunction

   task automatic send(input bq_t pre, input bq_t body);
      int lost, c, n, fwd;
      bit acc;
      lost = (prev_acc && last_gap < 3) ? 3 - last_gap : 0;
      acc  = accepts(pre, lost);
      n    = body.size();
      fwd  = (n > 4) ? ((n - 4 > MAX_LEN) ? MAX_LEN : n - 4) : 0;
      foreach (pre[i]) put(1'b1, pre[i], c);
      for (int j = 0; j < n; j++) begin
         put(1'b1, body[j], c);
         if (acc && j < fwd) begin
            exp_b.push_back(body[j]);
            exp_t.push_back(c + 6);
         end
      end
      if (acc) begin
         exp_ok.push_back((n >= 5) && (n - 4 <= MAX_LEN) && fcs_good(body));
         exp_len.push_back((n > MAX_LEN + 4) ? MAX_LEN : ((n >= 4) ? n - 4 : 0));
      end
      prev_acc = acc;
      last_gap = 0;
   endtask

   task automatic send_with_reset();
      bq_t pre, body;
      int c;
      phase = 1;
      pre  = pre_ok(7);
      body = with_fcs(rnd_bytes(60), 1'b0);
      foreach (pre[i]) put(1'b1, pre[i], c);
      for (int j = 0; j < body.size(); j++) begin
         put(1'b1, body[j], c);
         if (j == 20) begin
            rst = 1'b1;
            #1;
            chk("rst_mac_rxdv", 32'(bus.mac_rxdv), 32'd0);
            chk("rst_mac_rxd", 32'(bus.mac_rxd), 32'd0);
            chk("rst_fs_mac", 32'(bus.fs_mac), 32'd0);
            chk("rst_crc_en", 32'(bus.crc_en), 32'd0);
            chk("rst_status", 32'({bus.fd, bus.frame_ok, bus.frame_err}), 32'd0);
            chk("rst_len", 32'(bus.len), 32'd0);
            phase = 2;
         end
         if (j == 22) rst = 1'b0;
      end
      prev_acc = 1'b0;
      last_gap = 0;
      idle(8);
      phase = 0;
   endtask

   initial begin
      bq_t pay;
      int kind;
      bus.rxdv = 1'b0;
      bus.rxd  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({bus.mac_rxdv, bus.crc_en, bus.crc_clr, bus.fs_mac,
                                bus.fd, bus.frame_ok, bus.frame_err}), 32'd0);
      chk("reset_len", 32'(bus.len), 32'd0);
      chk("reset_mac_rxd", 32'(bus.mac_rxd), 32'd0);
      rst = 1'b0;
      idle(6);

      for (int i = 0; i < 60; i++) pay.push_back(8'(i));
      send(pre_ok(7), with_fcs(pay, 1'b0));
      idle(5);
      send(pre_ok(7), with_fcs(pay, 1'b1));
      idle(5);
      send('{8'h55, 8'hD5}, rnd_bytes(12));
      idle(4);
      send(pre_ok(7), with_fcs(rnd_bytes(20), 1'b0));
      idle(5);
      send('{8'h55, 8'h55, 8'hA5}, rnd_bytes(12));
      idle(4);
      send(pre_ok(7), with_fcs(rnd_bytes(20), 1'b0));
      idle(10);
      send_with_reset();
      send(pre_ok(7), with_fcs(rnd_bytes(30), 1'b0));
      idle(5);
      send(pre_ok(7), with_fcs(rnd_bytes(1600), 1'b0));
      idle(5);
      send(pre_ok(7), rnd_bytes(3));
      idle(5);
      send(pre_ok(7), rnd_bytes(0));
      idle(5);
      send(pre_ok(7), with_fcs(rnd_bytes(25), 1'b0));
      idle(1);
      send(pre_ok(7), with_fcs(rnd_bytes(25), 1'b0));
      idle(1);
      send(pre_ok(7), with_fcs(rnd_bytes(1), 1'b0));
      idle(4);

      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 5);
         case (kind)
            3: send(pre_ok($urandom_range(2, 7)), with_fcs(rnd_bytes($urandom_range(1, 70)), 1'b1));
            4: send(pre_ok($urandom_range(2, 7)), rnd_bytes($urandom_range(0, 4)));
            5: begin
               if (last_gap < 3) idle(3);
               if ($urandom_range(0, 1) == 0) send('{8'h55, 8'hD5}, rnd_bytes($urandom_range(5, 20)));
               else send('{8'h55, 8'h55, 8'hA5}, rnd_bytes($urandom_range(5, 20)));
            end
            default: send(pre_ok($urandom_range(2, 7)), with_fcs(rnd_bytes($urandom_range(1, 70)), 1'b0));
         endcase
         idle($urandom_range(1, 6));
      end

      idle(20);
      chk("drain_bytes", 32'(exp_b.size()), 32'd0);
      chk("drain_status", 32'(exp_ok.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout: bench did not complete at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
